dino_pose_rom: RTL and testbench



---
 rtl/dino_sprite_pkg.sv | 67 ++++++
 rtl/dino_pose_rom_if.sv | 10 +
 rtl/dino_duck_rom.sv | 8 +
 rtl/dino_godzilla_rom.sv | 8 +
 rtl/dino_jump_rom.sv | 8 +
 rtl/dino_pose_rom.sv | 23 ++
 tb/tb_dino_pose_rom.sv | 140 ++++++++++++++
 7 files changed

// File: rtl/dino_sprite_pkg.sv
// rtl/dino_sprite_pkg.sv - pose ids, geometry and constant row masks for the dino pose sprites
package dino_sprite_pkg;

  typedef enum logic [1:0] {SPR_JUMP, SPR_DUCK, SPR_GODZILLA} sprite_id_e;

  localparam int SPR_W  = 32;
  localparam int SPR_H  = 32;
  localparam int ADDR_W = 10;
  localparam int PIX_W  = 16;

  // One 32-bit mask per row; bit 31 is the leftmost column.
  localparam logic [SPR_W-1:0] JUMP_MASK [0:SPR_H-1] = '{
    32'h00000000, 32'h00007FE0, 32'h0000FFF0, 32'h0000CFF0,
    32'h0000FFF0, 32'h0000FFF0, 32'h0000FE00, 32'h0000FFC0,
    32'h4001FC00, 32'h4003F800, 32'h600FFE00, 32'h701FFA00,
    32'h7C7FF800, 32'h7FFFF800, 32'h3FFFF800, 32'h1FFFF000,
    32'h0FFFF000, 32'h07FFE000, 32'h03FFC000, 32'h01FF8000,
    32'h00F78000, 32'h00E38000, 32'h00C18000, 32'h00C18000,
    32'h00E1C000, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000
  };

  localparam logic [SPR_W-1:0] DUCK_MASK [0:SPR_H-1] = '{
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h4000FFFC,
    32'h6003FFFC, 32'h7FFFFFFC, 32'h7FFFFE70, 32'h3FFFFFFC,
    32'h1FFFFF00, 32'h0FFFFE00, 32'h07FFFC00, 32'h03FFF800,
    32'h01E3C000, 32'h01C38000, 32'h01830000, 32'h01830000,
    32'h01C3C000, 32'h00000000, 32'h00000000, 32'h00000000
  };

  localparam logic [SPR_W-1:0] GODZILLA_MASK [0:SPR_H-1] = '{
    32'h00000000, 32'h00003FC0, 32'h00007FE0, 32'h0000FFF0,
    32'h0000E7F0, 32'h0000FFF0, 32'h0001FFF0, 32'h0003FF00,
    32'h1007FF80, 32'h100FFFC0, 32'h181FFE00, 32'h1C3FFE00,
    32'h0E7FFF00, 32'h07FFFF80, 32'h03FFFFC0, 32'h01FFFFE0,
    32'h00FFFFF0, 32'h007FFFF8, 32'h003FFFFC, 32'h007FFFFC,
    32'h00FFFE3C, 32'h01FFFC1C, 32'h01FFF80C, 32'h03F3F000,
    32'h03E1F000, 32'h03C1E000, 32'h0381C000, 32'h0381C000,
    32'h0381C000, 32'h07C3E000, 32'h0FE7F000, 32'h00000000
  };

  localparam logic [4:0] LAST_COL = 5'(SPR_W - 1);

  function automatic logic [PIX_W-1:0] pixel_of(
    input int                sprite_id,
    input logic [ADDR_W-1:0] addr,
    input logic [PIX_W-1:0]  fg,
    input logic [PIX_W-1:0]  bg
  );
    logic [4:0] row;
    logic [4:0] bit_idx;
    logic       bit_set;
    row     = addr[9:5];
    bit_idx = LAST_COL - addr[4:0];
    case (sprite_id)
      int'(SPR_JUMP):     bit_set = JUMP_MASK[row][bit_idx];
      int'(SPR_DUCK):     bit_set = DUCK_MASK[row][bit_idx];
      int'(SPR_GODZILLA): bit_set = GODZILLA_MASK[row][bit_idx];
      default:            bit_set = 1'b0;
    endcase
    return bit_set ? fg : bg;
  endfunction

endpackage

// File: rtl/dino_pose_rom_if.sv
// rtl/dino_pose_rom_if.sv - pixel address in, colour word out, between compositor and sprite store
interface dino_pose_rom_if;
  import dino_sprite_pkg::*;

  logic [ADDR_W-1:0] address;
  logic [PIX_W-1:0]  data;

  modport master (output address, input data);
  modport slave  (input address, output data);
endinterface

// File: rtl/dino_duck_rom.sv
// rtl/dino_duck_rom.sv - legacy name for the duck pose store
module dino_duck_rom (
  input logic            clk,
  input logic            reset,
  dino_pose_rom_if.slave bus
);
  dino_pose_rom #(.SPRITE(1)) u_rom (.clk(clk), .reset(reset), .bus(bus));
endmodule

// File: rtl/dino_godzilla_rom.sv
// rtl/dino_godzilla_rom.sv - legacy name for the godzilla pose store
module dino_godzilla_rom (
  input logic            clk,
  input logic            reset,
  dino_pose_rom_if.slave bus
);
  dino_pose_rom #(.SPRITE(2)) u_rom (.clk(clk), .reset(reset), .bus(bus));
endmodule

// File: rtl/dino_jump_rom.sv
// rtl/dino_jump_rom.sv - legacy name for the jump pose store
module dino_jump_rom (
  input logic            clk,
  input logic            reset,
  dino_pose_rom_if.slave bus
);
  dino_pose_rom #(.SPRITE(0)) u_rom (.clk(clk), .reset(reset), .bus(bus));
endmodule

// File: rtl/dino_pose_rom.sv
// rtl/dino_pose_rom.sv - one-cycle registered RGB565 lookup of a 32x32 dino pose sprite
module dino_pose_rom
  import dino_sprite_pkg::*;
#(
  parameter int               SPRITE   = 0,
  parameter logic [PIX_W-1:0] FG_COLOR = 16'h5AEB,
  parameter logic [PIX_W-1:0] BG_COLOR = 16'hFFFF
) (
  input logic            clk,
  input logic            reset,
  dino_pose_rom_if.slave bus
);

  // Registered so the compositor always sees a clean one-cycle pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.data <= BG_COLOR;
    end else begin
      bus.data <= pixel_of(SPRITE, bus.address, FG_COLOR, BG_COLOR);
    end
  end

endmodule

// File: tb/tb_dino_pose_rom.sv
// tb/tb_dino_pose_rom.sv - directed checks of the dino pose sprite store and its wrappers
module tb_dino_pose_rom;
  import dino_sprite_pkg::*;

  localparam logic [15:0] FG  = 16'h5AEB;
  localparam logic [15:0] BG  = 16'hFFFF;
  localparam logic [15:0] RED = 16'hF800;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] addr;
  int         tests_run = 0;
  int         tests_failed = 0;
  int         diff_count = 0;

  dino_pose_rom_if if_jump ();
  dino_pose_rom_if if_jump_w ();
  dino_pose_rom_if if_duck ();
  dino_pose_rom_if if_godz ();
  dino_pose_rom_if if_blank ();
  dino_pose_rom_if if_red ();

  assign if_jump.address   = addr;
  assign if_jump_w.address = addr;
  assign if_duck.address   = addr;
  assign if_godz.address   = addr;
  assign if_blank.address  = addr;
  assign if_red.address    = addr;

  dino_pose_rom #(.SPRITE(0)) u_dut (.clk(clk), .reset(reset), .bus(if_jump));
  dino_jump_rom     u_jump_w (.clk(clk), .reset(reset), .bus(if_jump_w));
  dino_duck_rom     u_duck   (.clk(clk), .reset(reset), .bus(if_duck));
  dino_godzilla_rom u_godz   (.clk(clk), .reset(reset), .bus(if_godz));
  dino_pose_rom #(.SPRITE(3)) u_blank (.clk(clk), .reset(reset), .bus(if_blank));
  dino_pose_rom #(.SPRITE(2), .FG_COLOR(16'hF800)) u_red (.clk(clk), .reset(reset), .bus(if_red));

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Independent mask lookup: bit 31 of the row word is column 0.
  function automatic logic [15:0] golden(input int spr, input int a, input logic [15:0] fg);
    int   row;
    int   col;
    logic b;
    row = a / 32;
    col = a % 32;
    case (spr)
      0:       b = JUMP_MASK[row][31 - col];
      1:       b = DUCK_MASK[row][31 - col];
      2:       b = GODZILLA_MASK[row][31 - col];
      default: b = 1'b0;
    endcase
    return b ? fg : BG;
  endfunction

  task automatic read_at(input logic [9:0] a);
    @(negedge clk);
    addr = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    addr  = 10'd528;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_state", if_jump.data, BG);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_eq("first_read_after_reset", if_jump.data, FG);

    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_eq("async_reset_immediate", if_jump.data, BG);
    @(posedge clk);
    #1;
    check_eq("reset_held", if_jump.data, BG);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_eq("read_after_rerelease", if_jump.data, FG);

    read_at(10'd0);   check_eq("tput_0",   if_jump.data, BG);
    read_at(10'd528); check_eq("tput_528", if_jump.data, FG);
    read_at(10'd31);  check_eq("tput_31",  if_jump.data, BG);
    read_at(10'd528); check_eq("tput_528b", if_jump.data, FG);

    // Hand-decoded pixels: jump row 1 = 00007FE0 covers cols 17..26.
    read_at(10'd48); check_eq("jump_r1_c16", if_jump.data, BG);
    read_at(10'd49); check_eq("jump_r1_c17", if_jump.data, FG);
    read_at(10'd58); check_eq("jump_r1_c26", if_jump.data, FG);
    read_at(10'd59); check_eq("jump_r1_c27", if_jump.data, BG);
    // Duck row 15 = 4000FFFC: col 1 set, col 0 clear.
    read_at(10'd480); check_eq("duck_r15_c0", if_duck.data, BG);
    read_at(10'd481); check_eq("duck_r15_c1", if_duck.data, FG);
    read_at(10'd528);
    check_eq("godz_centre", if_godz.data, FG);
    check_eq("red_centre",  if_red.data,  RED);
    check_eq("blank_centre", if_blank.data, BG);

    for (int a = 0; a < 1024; a++) begin
      read_at(10'(a));
      check_eq($sformatf("sweep_jump_%0d", a),   if_jump.data,   golden(0, a, FG));
      check_eq($sformatf("sweep_jumpw_%0d", a),  if_jump_w.data, golden(0, a, FG));
      check_eq($sformatf("sweep_duck_%0d", a),   if_duck.data,   golden(1, a, FG));
      check_eq($sformatf("sweep_godz_%0d", a),   if_godz.data,   golden(2, a, FG));
      check_eq($sformatf("sweep_red_%0d", a),    if_red.data,    golden(2, a, RED));
      check_eq($sformatf("sweep_blank_%0d", a),  if_blank.data,  BG);
      if (a < 32 || a >= 992 || (a % 32) == 0 || (a % 32) == 31) begin
        check_eq($sformatf("border_jump_%0d", a), if_jump.data, BG);
        check_eq($sformatf("border_duck_%0d", a), if_duck.data, BG);
        check_eq($sformatf("border_godz_%0d", a), if_godz.data, BG);
      end
      if (a >= 32 && a <= 383)
        check_eq($sformatf("duck_top_clear_%0d", a), if_duck.data, BG);
      if (a >= 800)
        check_eq($sformatf("jump_bottom_clear_%0d", a), if_jump.data, BG);
      if (if_jump.data !== if_duck.data)
        diff_count++;
    end
    check_eq("jump_duck_differ", 16'(diff_count != 0), 16'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
